// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types for the traffic-light controller and its lane detector
`timescale 1ns/1ps
package tlc_pkg;
  typedef enum logic {YES = 1'b0, NO = 1'b1} boolean_t;
  typedef enum logic [2:0] {ABSENT, ARRIVING, PRESENT, DEPARTING, STUCK} det_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, both stages reset to 0
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  // shift the raw input through both stages
  always_comb ff_d = {ff_q[0], d};
  // synchronizer stages
  always_ff @(posedge clk or posedge rst)
    if (rst) ff_q <= '0;
    else ff_q <= ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/car_detector.sv
// car_detector: turns the raw farm-road loop signal into a debounced car_present flag
`timescale 1ns/1ps
module car_detector
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int HOLD      = 8,
  parameter int STUCK_MAX = 1024,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic             sample_en,
  input  logic             clear_fault,
  output logic             car_present,
  output logic             car_arrive,
  output logic [CNT_W-1:0] car_count,
  output logic             fault
);
  localparam int DMAX = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int SW   = $clog2(STUCK_MAX + 1);
  logic             s;
  det_state_t       state_q, state_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic [SW-1:0]    stuck_q, stuck_d, stuck_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic             arrive_q, arrive_d;
  boolean_t         present_q, present_d;
  logic             fault_q, fault_d;
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (loop_raw),
    .q   (s)
  );
  assign stuck_inc = stuck_q + SW'(1);
  // next state, counters and registered outputs; an arrival overrides the case result
  always_comb begin
    state_d  = state_q;
    deb_d    = deb_q;
    stuck_d  = stuck_q;
    count_d  = count_q;
    arrive_d = 1'b0;
    if (state_q == STUCK) begin
      if (clear_fault && !s) begin
        state_d = ABSENT;
        deb_d   = '0;
        stuck_d = '0;
      end
    end else if (sample_en) begin
      case (state_q)
        ABSENT: if (s) begin
          arrive_d = (DEBOUNCE == 1);
          state_d  = ARRIVING;
          deb_d    = DW'(1);
        end
        ARRIVING: if (!s) begin
          state_d = ABSENT;
          deb_d   = '0;
        end else if (deb_q == DW'(DEBOUNCE - 1)) arrive_d = 1'b1;
        else deb_d = deb_q + DW'(1);
        PRESENT: if (s) begin
          stuck_d = stuck_inc;
          state_d = (stuck_inc == SW'(STUCK_MAX)) ? STUCK : PRESENT;
        end else begin
          state_d = (HOLD == 1) ? ABSENT : DEPARTING;
          deb_d   = (HOLD == 1) ? DW'(0) : DW'(1);
          stuck_d = (HOLD == 1) ? SW'(0) : stuck_q;
        end
        DEPARTING: if (s) begin
          stuck_d = stuck_inc;
          deb_d   = '0;
          state_d = (stuck_inc == SW'(STUCK_MAX)) ? STUCK : PRESENT;
        end else if (deb_q == DW'(HOLD - 1)) begin
          state_d = ABSENT;
          deb_d   = '0;
          stuck_d = '0;
        end else deb_d = deb_q + DW'(1);
        default: ;
      endcase
      if (arrive_d) begin
        state_d = PRESENT;
        deb_d   = '0;
        stuck_d = SW'(DEBOUNCE);
        count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
      end
    end
    present_d = (state_d == ABSENT || state_d == ARRIVING) ? NO : YES;
    fault_d   = (state_d == STUCK);
  end
  // state, counters and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= ABSENT;
      deb_q     <= '0;
      stuck_q   <= '0;
      count_q   <= '0;
      arrive_q  <= 1'b0;
      present_q <= NO;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      stuck_q   <= stuck_d;
      count_q   <= count_d;
      arrive_q  <= arrive_d;
      present_q <= present_d;
      fault_q   <= fault_d;
    end
  assign car_present = present_q;
  assign car_arrive  = arrive_q;
  assign car_count   = count_q;
  assign fault       = fault_q;
endmodule

// File: doc/car_detector.md
Name: car_detector

Overview:
- Conditions the raw inductive-loop signal from the farm-road lane into the clean `car_present` flag that feeds the farm and highway light controllers.
- Replaces the nondeterministic sensor model with synthesizable logic: synchronization, arrival debounce, departure hold-off, arrival counting and stuck-sensor fault detection.
- Sits directly upstream of `farm_control` and `hwy_control`.

Parameters:
- DEBOUNCE, 4: consecutive high samples (>=1) required to declare a car present.
- HOLD, 8: consecutive low samples (>=1) required to declare the lane empty.
- STUCK_MAX, 1024: high samples in one occupancy that flag a stuck sensor; must be > DEBOUNCE.
- CNT_W, 8: width of the arrival counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- loop_raw  in  1  raw loop detector, asynchronous to clk.
- sample_en  in  1  sample tick; the FSM and counters advance only when it is 1.
- clear_fault  in  1  single-cycle request to clear a stuck fault.
- car_present  out  1  boolean, encoding YES=0, NO=1; registered.
- car_arrive  out  1  one-cycle pulse per debounced arrival.
- car_count  out  CNT_W  arrivals since reset; saturating.
- fault  out  1  sticky stuck-sensor flag.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=ABSENT, car_present=NO, car_arrive=0, car_count=0, fault=0, all counters 0, synchronizer flops 0.
  - Reset mid-occupancy abandons the occupancy; no pulse is generated.
- Synchronizer: loop_raw passes through 2 flops giving `s`, so there is 2 cycles of latency before the FSM sees an edge.
- Outputs are registered and reflect the state entered on the previous edge.
- Counters: deb_cnt must hold max(DEBOUNCE, HOLD). stuck_cnt must hold STUCK_MAX.
- sample_en=0: state and all counters hold; car_arrive=0.
- ABSENT (car_present=NO, stuck_cnt=0):
  - If sample_en&&s and DEBOUNCE==1: go to PRESENT, arrival event.
  - If sample_en&&s and DEBOUNCE>1: go to ARRIVING, deb_cnt=1.
- ARRIVING (car_present=NO):
  - sample_en&&!s: go to ABSENT, deb_cnt=0 (glitch rejected).
  - sample_en&&s with deb_cnt==DEBOUNCE-1: go to PRESENT, arrival event.
  - sample_en&&s otherwise: deb_cnt+1.
- Arrival event:
  - car_arrive=1 for exactly one cycle.
  - car_count+1, saturating at 2^CNT_W-1.
  - stuck_cnt=DEBOUNCE.
- PRESENT (car_present=YES):
  - sample_en&&s: stuck_cnt+1. When it reaches STUCK_MAX, go to STUCK and set fault=1.
  - sample_en&&!s with HOLD==1: go to ABSENT.
  - sample_en&&!s with HOLD>1: go to DEPARTING, deb_cnt=1.
- DEPARTING (car_present=YES):
  - sample_en&&s: go to PRESENT, stuck_cnt+1. No new arrival and no count increment.
  - sample_en&&!s with deb_cnt==HOLD-1: go to ABSENT.
  - sample_en&&!s otherwise: deb_cnt+1.
- STUCK (car_present=YES as fail-safe, fault=1):
  - clear_fault&&!s (independent of sample_en): go to ABSENT, fault=0, counters 0.
  - clear_fault&&s: ignored.
  - clear_fault in any other state: no effect.
- Simultaneous events: reaching STUCK_MAX on the same sample that would otherwise stay in PRESENT goes to STUCK.
- car_count saturation: the car_arrive pulse is still emitted.

Decomposition:
- Shared package `tlc_pkg`:
  - boolean enum {YES, NO} (shared with the light controllers).
  - detector state enum {ABSENT, ARRIVING, PRESENT, DEPARTING, STUCK}.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with async active-high reset to 0.

Test Plan:
All scenarios use DEBOUNCE=4, HOLD=8, STUCK_MAX=16, CNT_W=8 and sample_en tied to 1 unless stated.
1. Arrival: after reset, loop_raw goes 0->1 and is held. car_present=YES on the 6th rising edge after the rise (2 synchronizer + 4 debounce). car_arrive is high exactly 1 cycle and car_count=1.
2. Glitch: loop_raw high for 3 cycles, then low. car_present stays NO, car_arrive never pulses, car_count=0.
3. Departure with bounce: in PRESENT, loop_raw drops and is low 5 cycles, then high 1 cycle, then low. car_present stays YES throughout and car_count stays 1. It returns to NO 8 samples after the final fall.
4. Stuck sensor: loop_raw held high. fault=1 and state=STUCK after 16 high samples, with car_present=YES. clear_fault while high is ignored. loop_raw low, 2 cycles wait, then clear_fault gives fault=0 and car_present=NO.
5. Saturation/sample_en: CNT_W=2, 5 clean arrivals give car_count=3 with 5 car_arrive pulses. Holding sample_en=0 for 10 cycles mid-ARRIVING freezes deb_cnt and car_present.
6. Async reset: assert rst mid-DEPARTING, between clock edges. car_present=NO, car_count=0 and fault=0 immediately, without waiting for a clk edge.
